// File: rtl/alu_operand_stage.sv
// Operand stage between decode and EX: per-source MEM/WB forwarding, immediate
// selection, load-use stall detection and the registered EX payload.
module alu_operand_stage #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [ADDR_W-1:0] id_rs1,
   input  logic [ADDR_W-1:0] id_rs2,
   input  logic [DATA_W-1:0] id_reg1_val,
   input  logic [DATA_W-1:0] id_reg2_val,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_use_imm,
   input  logic [ADDR_W-1:0] id_rd,
   input  logic              id_rd_we,
   input  logic              id_is_load,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic              mem_we,
   input  logic [DATA_W-1:0] mem_val,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic              wb_we,
   input  logic [DATA_W-1:0] wb_val,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_op1,
   output logic [DATA_W-1:0] ex_op2,
   output logic [ADDR_W-1:0] ex_rd,
   output logic              ex_rd_we,
   output logic              ex_is_load,
   output logic [1:0]        fwd1_sel,
   output logic [1:0]        fwd2_sel,
   input  logic              clr_stats,
   output logic [15:0]       stall_cnt
);

   typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

   state_t            state;
   logic              rs1_zero_p0;
   logic              rs2_zero_p0;
   logic [DATA_W-1:0] op1_p0;
   logic [DATA_W-1:0] op2_p0;
   logic [1:0]        sel1_p0;
   logic [1:0]        sel2_p0;
   logic              hit1_p0;
   logic              hit2_p0;
   logic              load_use_p0;
   logic              take_p0;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // ---- decode side (p0): operand selection and hazard detection ----
   assign rs1_zero_p0 = ZERO_REG && (id_rs1 == '0);
   assign rs2_zero_p0 = ZERO_REG && (id_rs2 == '0);

   always_comb begin
      op1_p0  = id_reg1_val;
      sel1_p0 = 2'd0;
      if (rs1_zero_p0) begin
         op1_p0  = '0;
         sel1_p0 = 2'd0;
      end else if (mem_we && (mem_rd == id_rs1)) begin
         op1_p0  = mem_val;
         sel1_p0 = 2'd1;
      end else if (wb_we && (wb_rd == id_rs1)) begin
         op1_p0  = wb_val;
         sel1_p0 = 2'd2;
      end
   end

   always_comb begin
      op2_p0  = id_reg2_val;
      sel2_p0 = 2'd0;
      if (id_use_imm) begin
         op2_p0  = id_imm;
         sel2_p0 = 2'd3;
      end else if (rs2_zero_p0) begin
         op2_p0  = '0;
         sel2_p0 = 2'd0;
      end else if (mem_we && (mem_rd == id_rs2)) begin
         op2_p0  = mem_val;
         sel2_p0 = 2'd1;
      end else if (wb_we && (wb_rd == id_rs2)) begin
         op2_p0  = wb_val;
         sel2_p0 = 2'd2;
      end
   end

   // A load in EX cannot forward its data yet, so a consumer must wait a cycle.
   assign hit1_p0     = (ex_rd == id_rs1) && !rs1_zero_p0;
   assign hit2_p0     = (ex_rd == id_rs2) && !rs2_zero_p0 && !id_use_imm;
   assign load_use_p0 = id_valid && ex_valid && ex_is_load && ex_rd_we &&
                        (hit1_p0 || hit2_p0);
   assign id_ready    = ex_ready && !load_use_p0;
   assign take_p0     = id_valid && id_ready;

   // ---- EX register (p1), stall FSM and statistics ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         stall_cnt  <= '0;
         ex_valid   <= 1'b0;
         ex_op1     <= '0;
         ex_op2     <= '0;
         ex_rd      <= '0;
         ex_rd_we   <= 1'b0;
         ex_is_load <= 1'b0;
         fwd1_sel   <= 2'd0;
         fwd2_sel   <= 2'd0;
      end else begin
         if (clr_stats)
            stall_cnt <= '0;
         else if (ex_ready && load_use_p0 && (state == RUN))
            stall_cnt <= sat_inc(stall_cnt);
         else
            stall_cnt <= stall_cnt;

         if (ex_ready) begin
            case (state)
               RUN:      if (load_use_p0) state <= LU_STALL;
               LU_STALL: state <= RUN;
               default:  state <= RUN;
            endcase

            if (take_p0) begin
               ex_valid   <= 1'b1;
               ex_op1     <= op1_p0;
               ex_op2     <= op2_p0;
               ex_rd      <= id_rd;
               ex_rd_we   <= id_rd_we;
               ex_is_load <= id_is_load;
               fwd1_sel   <= sel1_p0;
               fwd2_sel   <= sel2_p0;
            end else begin
               ex_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: a cycle-level reference model checked on
// every clock, plus literal expectations for the key scenarios.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_ready;
   logic [2:0]  id_rs1, id_rs2, id_rd;
   logic [15:0] id_reg1_val, id_reg2_val, id_imm;
   logic        id_use_imm, id_rd_we, id_is_load;
   logic [2:0]  mem_rd, wb_rd;
   logic        mem_we, wb_we;
   logic [15:0] mem_val, wb_val;
   logic        ex_ready, ex_valid;
   logic [15:0] ex_op1, ex_op2;
   logic [2:0]  ex_rd;
   logic        ex_rd_we, ex_is_load;
   logic [1:0]  fwd1_sel, fwd2_sel;
   logic        clr_stats;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_reg1_val(id_reg1_val), .id_reg2_val(id_reg2_val),
      .id_imm(id_imm), .id_use_imm(id_use_imm),
      .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
      .mem_rd(mem_rd), .mem_we(mem_we), .mem_val(mem_val),
      .wb_rd(wb_rd), .wb_we(wb_we), .wb_val(wb_val),
      .ex_ready(ex_ready), .ex_valid(ex_valid),
      .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd),
      .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
      .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
      .clr_stats(clr_stats), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic        m_valid, m_rd_we, m_is_load;
   logic [15:0] m_op1, m_op2, m_cnt;
   logic [2:0]  m_rd;
   logic [1:0]  m_sel1, m_sel2;

   // Returns {select, value} for one source following the forwarding priority.
   function automatic logic [17:0] pick(input logic [2:0] rs, input logic [15:0] rf);
      if (rs == 3'd0)                return {2'd0, 16'h0000};
      if (mem_we && mem_rd == rs)    return {2'd1, mem_val};
      if (wb_we && wb_rd == rs)      return {2'd2, wb_val};
      return {2'd0, rf};
   endfunction

   function automatic logic model_lu();
      logic dep;
      dep = (id_rs1 != 3'd0 && id_rs1 == m_rd) ||
            (!id_use_imm && id_rs2 != 3'd0 && id_rs2 == m_rd);
      return id_valid && m_valid && m_is_load && m_rd_we && dep;
   endfunction

   always @(posedge clk) begin
      logic        lu;
      logic [17:0] p1, p2;
      if (!rst_n) begin
         m_valid = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_rd_we = 0;
         m_is_load = 0; m_sel1 = 0; m_sel2 = 0; m_cnt = 0;
      end else begin
         lu = model_lu();
         if (ex_ready) begin
            if (id_valid && !lu) begin
               p1 = pick(id_rs1, id_reg1_val);
               p2 = id_use_imm ? {2'd3, id_imm} : pick(id_rs2, id_reg2_val);
               m_valid = 1; m_op1 = p1[15:0]; m_sel1 = p1[17:16];
               m_op2 = p2[15:0]; m_sel2 = p2[17:16];
               m_rd = id_rd; m_rd_we = id_rd_we; m_is_load = id_is_load;
            end else begin
               m_valid = 0;
            end
         end
         if (clr_stats)                                m_cnt = 0;
         else if (ex_ready && lu && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      #1;
      chk("m_ex_valid", ex_valid, m_valid);
      chk("m_stall_cnt", stall_cnt, m_cnt);
      chk("m_id_ready", id_ready, ex_ready && !model_lu());
      if (m_valid) begin
         chk("m_ex_op1", ex_op1, m_op1);
         chk("m_ex_op2", ex_op2, m_op2);
         chk("m_ex_rd", ex_rd, m_rd);
         chk("m_ex_rd_we", ex_rd_we, m_rd_we);
         chk("m_ex_is_load", ex_is_load, m_is_load);
         chk("m_fwd1_sel", fwd1_sel, m_sel1);
         chk("m_fwd2_sel", fwd2_sel, m_sel2);
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      id_valid = 0; id_rs1 = 1; id_rs2 = 1; id_rd = 0;
      id_reg1_val = 16'h1111; id_reg2_val = 16'h2222; id_imm = 0;
      id_use_imm = 0; id_rd_we = 0; id_is_load = 0;
      mem_rd = 0; mem_we = 0; mem_val = 0; wb_rd = 0; wb_we = 0; wb_val = 0;
      ex_ready = 1; clr_stats = 0;
   endtask

   task automatic instr(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                        input logic load);
      id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rd_we = 1; id_is_load = load; id_use_imm = 0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_valid"}, ex_valid, 0);
      chk({tag, "_op1"}, ex_op1, 0);
      chk({tag, "_op2"}, ex_op2, 0);
      chk({tag, "_rd"}, ex_rd, 0);
      chk({tag, "_we_ld"}, {ex_rd_we, ex_is_load}, 0);
      chk({tag, "_sel"}, {fwd1_sel, fwd2_sel}, 0);
      chk({tag, "_cnt"}, stall_cnt, 0);
   endtask

   initial begin
      rst_n = 0;
      idle();
      step(); step();
      chk_reset_outs("rst");
      rst_n = 1;

      // MEM wins over WB for the same register
      instr(3'd2, 3'd4, 3'd6, 0);
      mem_we = 1; mem_rd = 2; mem_val = 16'h1234;
      wb_we = 1; wb_rd = 2; wb_val = 16'hBEEF;
      step();
      chk("mem_prio_op1", ex_op1, 16'h1234);
      chk("mem_prio_sel1", fwd1_sel, 1);
      chk("rf_op2", ex_op2, 16'h2222);
      chk("mem_prio_valid", ex_valid, 1);

      // WB-only match
      instr(3'd3, 3'd3, 3'd6, 0);
      wb_rd = 3;
      step();
      chk("wb_op1", ex_op1, 16'hBEEF);
      chk("wb_sel2", fwd2_sel, 2);

      // Immediate overrides a MEM match on rs2
      instr(3'd1, 3'd5, 3'd6, 0);
      id_use_imm = 1; id_imm = 16'hFFF0; mem_rd = 5; mem_we = 1; wb_we = 0;
      step();
      chk("imm_op2", ex_op2, 16'hFFF0);
      chk("imm_sel2", fwd2_sel, 3);

      // Register 0 never forwards
      instr(3'd0, 3'd1, 3'd6, 0);
      id_reg1_val = 16'h7777; mem_we = 1; mem_rd = 0; mem_val = 16'h5555;
      step();
      chk("zero_op1", ex_op1, 16'h0000);
      chk("zero_sel1", fwd1_sel, 0);

      // Load-use: load rd=3 then consumer of r3
      idle();
      instr(3'd1, 3'd1, 3'd3, 1);
      step();
      instr(3'd3, 3'd1, 3'd4, 0);
      #1 chk("lu_id_ready", id_ready, 0);
      step();
      chk("lu_bubble", ex_valid, 0);
      chk("lu_cnt", stall_cnt, 1);
      mem_we = 1; mem_rd = 3; mem_val = 16'h00AA;
      #1 chk("lu_release_ready", id_ready, 1);
      step();
      chk("lu_op1", ex_op1, 16'h00AA);
      chk("lu_sel1", fwd1_sel, 1);
      chk("lu_valid", ex_valid, 1);

      // EX back-pressure holds everything
      ex_ready = 0;
      instr(3'd2, 3'd2, 3'd7, 1);
      mem_val = 16'h9999;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_op1", ex_op1, 16'h00AA);
         chk("hold_rd", ex_rd, 4);
         chk("hold_valid", ex_valid, 1);
         chk("hold_ready", id_ready, 0);
      end
      ex_ready = 1; mem_we = 0;

      // rs2 match masked by immediate: no stall
      instr(3'd1, 3'd1, 3'd3, 1);
      step();
      instr(3'd1, 3'd3, 3'd5, 0);
      id_use_imm = 1; id_imm = 16'h0042;
      #1 chk("imm_no_lu", id_ready, 1);
      step();
      chk("imm_no_lu_valid", ex_valid, 1);

      // Saturation of the stall counter
      idle();
      instr(3'd1, 3'd1, 3'd2, 1);
      step();
      force dut.stall_cnt = 16'hFFFF;
      m_cnt = 16'hFFFF;
      #1 release dut.stall_cnt;
      instr(3'd2, 3'd1, 3'd2, 1);
      step();
      chk("sat_cnt", stall_cnt, 16'hFFFF);
      chk("sat_bubble", ex_valid, 0);
      step();
      clr_stats = 1;
      step();
      chk("clr_wins", stall_cnt, 0);
      clr_stats = 0;
      step();
      step();
      chk("stall_again", stall_cnt, 1);

      // Reset in the middle of a stall
      #2 rst_n = 0;
      #1 chk_reset_outs("mid_rst");
      step();
      rst_n = 1;
      idle();
      instr(3'd2, 3'd1, 3'd5, 0);
      step();
      chk("post_rst_valid", ex_valid, 1);
      chk("post_rst_op1", ex_op1, 16'h1111);
      chk("post_rst_cnt", stall_cnt, 0);
      idle();
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, operand/data width; ADDR_W, default 3, register address width; ZERO_REG, default 1, when 1 register 0 reads as zero and is never forwarded.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports, clock and reset first:
 clk  in  1  rising-edge clock
 rst_n  in  1  asynchronous active-low reset
 id_valid  in  1  decode stage presents an instruction
 id_ready  out  1  block accepts the decode instruction this cycle
 id_rs1, id_rs2  in  ADDR_W  source register addresses
 id_reg1_val, id_reg2_val  in  DATA_W  register-file read data
 id_imm  in  DATA_W  sign-extended constant
 id_use_imm  in  1  operand 2 takes id_imm
 id_rd  in  ADDR_W  destination address; id_rd_we  in  1  writes rd; id_is_load  in  1  load instruction
 mem_rd  in  ADDR_W; mem_we  in  1; mem_val  in  DATA_W  MEM-stage result
 wb_rd  in  ADDR_W; wb_we  in  1; wb_val  in  DATA_W  WB-stage result
 ex_ready  in  1  EX stage consumes the EX register this cycle
 ex_valid  out  1; ex_op1, ex_op2  out  DATA_W; ex_rd  out  ADDR_W; ex_rd_we, ex_is_load  out  1  registered EX payload
 fwd1_sel, fwd2_sel  out  2  registered select used: 0 regfile, 1 MEM, 2 WB, 3 immediate (op2 only)
 clr_stats  in  1  synchronous clear of stall_cnt
 stall_cnt  out  16  saturating load-use stall count

Function
REQ-003 Per source N, fwdN SHALL be MEM if mem_we and mem_rd==id_rsN, else WB if wb_we and wb_rd==id_rsN, else regfile; MEM SHALL take priority over WB.
REQ-004 With ZERO_REG=1 and id_rsN==0, the operand SHALL be zero and the select 0, regardless of forward matches.
REQ-005 When id_use_imm=1, operand 2 SHALL be id_imm with fwd2_sel=3; operand 1 forwarding is unaffected.
REQ-006 load_use SHALL be asserted combinationally when ex_valid, ex_is_load, ex_rd_we and ex_rd matches id_rs1, or id_rs2 with id_use_imm=0 (excluding addr 0 when ZERO_REG=1), and id_valid=1.
REQ-007 id_ready SHALL equal ex_ready AND NOT load_use.
REQ-008 FSM states RUN and LU_STALL; RUN->LU_STALL when load_use and ex_ready; LU_STALL->RUN unconditionally next cycle, re-evaluating the held instruction.
REQ-009 On a clock edge with ex_ready=1: if id_valid and id_ready, the EX register SHALL load the selected operands, id_rd, id_rd_we, id_is_load, selects and set ex_valid=1 (one-cycle latency); otherwise ex_valid SHALL become 0 (bubble).
REQ-010 With ex_ready=0 the EX register and all ex_* outputs SHALL hold, no bubble is inserted, and the FSM SHALL not change state.
REQ-011 stall_cnt SHALL increment by 1 on each RUN->LU_STALL transition, saturate at 0xFFFF, and clear on clr_stats; clr_stats coinciding with an increment SHALL yield 0.
REQ-012 Combinational forwarding SHALL use DATA_W-bit values without truncation or extension; address compares use all ADDR_W bits.

Reset
REQ-013 While rst_n=0: ex_valid=0, ex_op1=ex_op2=0, ex_rd=0, ex_rd_we=0, ex_is_load=0, fwd1_sel=fwd2_sel=0, stall_cnt=0, FSM=RUN, asynchronously.
REQ-014 Reset asserted mid-stall SHALL discard the bubble and held instruction; first edge after release behaves as RUN with ex_valid=0.

Verification
REQ-015 rs1=2, mem_we=1 mem_rd=2 mem_val=0x1234, wb_we=1 wb_rd=2 wb_val=0xBEEF -> next cycle ex_op1=0x1234, fwd1_sel=1.
REQ-016 rs2=5, use_imm=1, imm=0xFFF0, mem_rd=5 mem_we=1 -> ex_op2=0xFFF0, fwd2_sel=3.
REQ-017 EX holds load rd=3, decode rs1=3, ex_ready=1 -> id_ready=0, next ex_valid=0, stall_cnt=1; following cycle with mem_rd=3 mem_val=0x00AA -> ex_op1=0x00AA, fwd1_sel=1.
REQ-018 rs1=0, reg1_val=0x7777, mem_we=1 mem_rd=0 mem_val=0x5555 (ZERO_REG=1) -> ex_op1=0, fwd1_sel=0.
REQ-019 ex_ready=0 for 3 cycles with id_valid=1 -> ex_* unchanged, id_ready=0; stall_cnt forced to 0xFFFF then another stall -> stays 0xFFFF; rst_n low mid-stall -> all outputs per REQ-013.
